// File: rtl/mac_pipeline_multi_pkg.sv
// Shared definitions for the multi-lane MAC pipeline.
//   clog2        : ceiling log2 used for adder-tree growth
//   prod_width   : width of one lane product (2*WIDTH)
//   sum_width    : width of the reduced lane sum (2*WIDTH + clog2(LANES))
//   tag_t        : per-beat control bundle carried alongside the datapath
package mac_pipeline_multi_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int sum_width(input int width, input int lanes);
        return 2 * width + clog2(lanes);
    endfunction

    typedef struct packed {
        logic valid;
        logic clr;
        logic done;
    } tag_t;

endpackage

// File: rtl/mac_pipeline_multi_product_tree.sv
// Datapath front end: LANES unsigned multipliers (registered as S1) and a
// binary adder tree over the registered products (registered as S2).
//   clk, rst      : clock, async active-high reset
//   stall         : hold both register stages
//   filter, ifmap : LANES packed operands, lane k at [k*WIDTH +: WIDTH]
//   sum           : registered S2 lane sum, SUM_W bits
module mac_pipeline_multi_product_tree
    import mac_pipeline_multi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int SUM_W = sum_width(WIDTH, LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [LANES*WIDTH-1:0] filter,
    input  logic [LANES*WIDTH-1:0] ifmap,
    output logic [SUM_W-1:0]       sum
);

    localparam int PROD_W = prod_width(WIDTH);

    logic [LANES-1:0][PROD_W-1:0] prod_d;
    logic [LANES-1:0][PROD_W-1:0] prod_q;
    // Heap-ordered tree: node[1] is the root, leaves sit at LANES..2*LANES-1.
    logic [SUM_W-1:0]             node [1:2*LANES-1];
    logic [SUM_W-1:0]             tree_sum;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_d[k] = PROD_W'(filter[k*WIDTH +: WIDTH]) * PROD_W'(ifmap[k*WIDTH +: WIDTH]);
        end
    end

    // Sum never exceeds SUM_W bits, so no carry is lost at any node.
    always_comb begin
        for (int i = 1; i < 2 * LANES; i++) node[i] = '0;
        for (int k = 0; k < LANES; k++) node[LANES+k] = SUM_W'(prod_q[k]);
        for (int i = LANES - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    end

    assign tree_sum = node[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            sum    <= '0;
        end else if (!stall) begin
            prod_q <= prod_d;
            sum    <= tree_sum;
        end
    end

endmodule

// File: rtl/mac_pipeline_multi.sv
// Multi-lane multiply-accumulate pipeline for the PE datapath.
// Three register stages: products (S1), lane sum (S2), accumulator (S3).
//   clk, rst       : clock, async active-high reset
//   run            : operand beat valid
//   clr_pipe_in    : beat starts a new accumulation (with run)
//   done_psum_in   : beat ends the accumulation (with run)
//   stall          : freeze every stage, inputs ignored
//   sat_en         : clamp (1) or wrap (0) on accumulator overflow
//   Filter, IFMap  : LANES packed unsigned operands
//   Psum           : accumulator value
//   psum_valid     : Psum updated by a beat
//   done_psum      : Psum holds the final value of an accumulation
//   overflow       : sticky overflow since the last clr beat
module mac_pipeline_multi
    import mac_pipeline_multi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   clr_pipe_in,
    input  logic                   done_psum_in,
    input  logic                   stall,
    input  logic                   sat_en,
    input  logic [LANES*WIDTH-1:0] Filter,
    input  logic [LANES*WIDTH-1:0] IFMap,
    output logic [ACC_WIDTH-1:0]   Psum,
    output logic                   psum_valid,
    output logic                   done_psum,
    output logic                   overflow
);

    localparam int SUM_W  = sum_width(WIDTH, LANES);
    localparam int ACC_W1 = ACC_WIDTH + 1;

    if (ACC_WIDTH < SUM_W) begin : g_bad_acc
        $error("mac_pipeline_multi: ACC_WIDTH must be >= 2*WIDTH+clog2(LANES)");
    end
    if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("mac_pipeline_multi: LANES must be a power of two in 1..16");
    end

    logic [SUM_W-1:0]  sum_s2;
    tag_t              tag_s1;
    tag_t              tag_s2;
    logic [ACC_W1-1:0] acc_next;
    logic              acc_ovf;

    mac_pipeline_multi_product_tree #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_tree (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .filter (Filter),
        .ifmap  (IFMap),
        .sum    (sum_s2)
    );

    // One extra bit on the add exposes the carry used for overflow.
    always_comb begin
        if (tag_s2.clr) acc_next = ACC_W1'(sum_s2);
        else            acc_next = {1'b0, Psum} + ACC_W1'(sum_s2);
        acc_ovf = acc_next[ACC_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_s1     <= '0;
            tag_s2     <= '0;
            Psum       <= '0;
            psum_valid <= 1'b0;
            done_psum  <= 1'b0;
            overflow   <= 1'b0;
        end else if (!stall) begin
            // clr/done are only meaningful on a valid beat.
            tag_s1     <= '{valid: run, clr: run & clr_pipe_in, done: run & done_psum_in};
            tag_s2     <= tag_s1;
            psum_valid <= tag_s2.valid;
            done_psum  <= tag_s2.valid & tag_s2.done;
            if (tag_s2.valid) begin
                if (acc_ovf && sat_en) Psum <= '1;
                else                   Psum <= acc_next[ACC_WIDTH-1:0];
                // A clr beat restarts the sticky flag from its own result.
                overflow <= (overflow & ~tag_s2.clr) | acc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipeline_multi.sv
// Directed bench for mac_pipeline_multi (WIDTH=8, LANES=4, ACC_WIDTH=20).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge.
module tb_mac_pipeline_multi;

    localparam int WIDTH     = 8;
    localparam int LANES     = 4;
    localparam int ACC_WIDTH = 20;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   run;
    logic                   clr_pipe_in;
    logic                   done_psum_in;
    logic                   stall;
    logic                   sat_en;
    logic [LANES*WIDTH-1:0] Filter;
    logic [LANES*WIDTH-1:0] IFMap;
    logic [ACC_WIDTH-1:0]   Psum;
    logic                   psum_valid;
    logic                   done_psum;
    logic                   overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_pipeline_multi #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .ACC_WIDTH (ACC_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .clr_pipe_in  (clr_pipe_in),
        .done_psum_in (done_psum_in),
        .stall        (stall),
        .sat_en       (sat_en),
        .Filter       (Filter),
        .IFMap        (IFMap),
        .Psum         (Psum),
        .psum_valid   (psum_valid),
        .done_psum    (done_psum),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic c, input logic d,
                         input logic [31:0] f, input logic [31:0] i);
        run          = r;
        clr_pipe_in  = c;
        done_psum_in = d;
        Filter       = f;
        IFMap        = i;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // n back-to-back beats, clr on the first and done on the last; returns
    // with the done beat's result visible.
    task automatic run_acc(input int n, input logic [31:0] f, input logic [31:0] i);
        for (int b = 0; b < n; b++) begin
            drive(1'b1, b == 0, b == n - 1, f, i);
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] f2, i36, ff, f1, i10;
        int          pulses;
        int          done_at;
        int          stray;

        f2  = pk(2, 2, 2, 2);
        i36 = pk(3, 4, 5, 6);   // 2*(3+4+5+6) = 36
        ff  = pk(255, 255, 255, 255);
        f1  = pk(1, 1, 1, 1);
        i10 = pk(1, 2, 3, 4);   // 10

        rst    = 1'b1;
        stall  = 1'b0;
        sat_en = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_psum",  32'(Psum), 32'd0);
        chk("rst_valid", 32'(psum_valid), 32'd0);
        chk("rst_done",  32'(done_psum), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single beat: result visible after the third rising edge.
        drive(1'b1, 1'b1, 1'b1, f2, i36);
        tick();
        idle();
        tick();
        chk("one_early_valid", 32'(psum_valid), 32'd0);
        tick();
        chk("one_psum",  32'(Psum), 32'd36);
        chk("one_valid", 32'(psum_valid), 32'd1);
        chk("one_done",  32'(done_psum), 32'd1);
        chk("one_ovf",   32'(overflow), 32'd0);
        tick();
        chk("one_valid_end", 32'(psum_valid), 32'd0);
        chk("one_done_end",  32'(done_psum), 32'd0);
        chk("one_psum_hold", 32'(Psum), 32'd36);

        // Four beats of 4*255*255 = 260100.
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, c == 0, c == 3, ff, ff);
            else       idle();
            tick();
            if (c >= 2 && c <= 5) begin
                chk($sformatf("acc4_psum%0d", c), 32'(Psum), 32'(260100 * (c - 1)));
                chk($sformatf("acc4_done%0d", c), 32'(done_psum), 32'(c == 5));
            end
        end
        chk("acc4_ovf", 32'(overflow), 32'd0);

        // Five beats: 1300500 exceeds 2^20-1 = 1048575.
        sat_en = 1'b1;
        run_acc(5, ff, ff);
        chk("sat_psum", 32'(Psum), 32'd1048575);
        chk("sat_ovf",  32'(overflow), 32'd1);
        chk("sat_done", 32'(done_psum), 32'd1);
        sat_en = 1'b0;
        run_acc(5, ff, ff);
        chk("wrap_psum", 32'(Psum), 32'd251924);   // 1300500 - 1048576
        chk("wrap_ovf",  32'(overflow), 32'd1);
        run_acc(1, f2, i36);
        chk("clr_ovf",  32'(overflow), 32'd0);
        chk("clr_psum", 32'(Psum), 32'd36);

        // Stall and bubble: b1(clr) / gap with stray clr+done / b2 /
        // 2 stalled cycles carrying a live beat that must be ignored / b3(done).
        pulses  = 0;
        done_at = -1;
        for (int c = 0; c < 10; c++) begin
            stall = 1'b0;
            case (c)
                0:       drive(1'b1, 1'b1, 1'b0, f2, i36);
                1:       drive(1'b0, 1'b1, 1'b1, f2, i36);
                2:       drive(1'b1, 1'b0, 1'b0, f2, i36);
                3, 4:    begin drive(1'b1, 1'b1, 1'b1, ff, ff); stall = 1'b1; end
                5:       drive(1'b1, 1'b0, 1'b1, f2, i36);
                default: idle();
            endcase
            tick();
            if (psum_valid && !stall) pulses++;
            if (done_psum && !stall && done_at < 0) done_at = c;
            if (c >= 2) begin
                chk($sformatf("stl_psum%0d", c), 32'(Psum),
                    32'((c >= 7) ? 108 : (c == 6) ? 72 : 36));
                chk($sformatf("stl_valid%0d", c), 32'(psum_valid),
                    32'(c == 2 || c == 3 || c == 4 || c == 6 || c == 7));
                chk($sformatf("stl_done%0d", c), 32'(done_psum), 32'(c == 7));
            end
        end
        stall = 1'b0;
        chk("stl_pulses", 32'(pulses), 32'd3);
        // b1 driven in cycle 0; b3 lands 3 pipeline edges after its drive
        // in cycle 5 (cycle 0 + b1 + gap + b2 + 2 stall).
        chk("stl_done_at", 32'(done_at), 32'd7);

        // Async reset with two beats in flight, after setting overflow.
        run_acc(5, ff, ff);
        drive(1'b1, 1'b1, 1'b0, f2, i36);
        tick();
        drive(1'b1, 1'b0, 1'b1, f2, i36);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_psum",  32'(Psum), 32'd0);
        chk("arst_valid", 32'(psum_valid), 32'd0);
        chk("arst_done",  32'(done_psum), 32'd0);
        chk("arst_ovf",   32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (psum_valid || done_psum) stray++;
        end
        chk("arst_stray", 32'(stray), 32'd0);
        chk("arst_psum_after", 32'(Psum), 32'd0);

        // Back-to-back single-beat accumulations.
        drive(1'b1, 1'b1, 1'b1, f2, i36);
        tick();
        drive(1'b1, 1'b1, 1'b1, f1, i10);
        tick();
        idle();
        tick();
        chk("b2b_a_psum", 32'(Psum), 32'd36);
        chk("b2b_a_done", 32'(done_psum), 32'd1);
        tick();
        chk("b2b_b_psum",  32'(Psum), 32'd10);
        chk("b2b_b_done",  32'(done_psum), 32'd1);
        chk("b2b_b_valid", 32'(psum_valid), 32'd1);
        tick();
        chk("b2b_end_done", 32'(done_psum), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_pipeline_multi.md
Name: mac_pipeline_multi

Overview:
- Parametrised successor of the single-lane multiply-accumulate pipeline used in the PE datapath.
- Consumes LANES filter/ifmap operand pairs per beat, multiplies them in parallel, reduces the products through an adder tree, and accumulates into a wide partial sum.
- Adds a runtime saturation mode, a sticky overflow flag and a psum_valid strobe.
- Sits between the PE scratchpad read stage and the psum writeback, with the same run/clear/done/stall control style.

Parameters:
- WIDTH, 8: unsigned operand width per lane.
- LANES, 4: parallel multiply lanes; power of two, 1..16.
- ACC_WIDTH, 24: accumulator and psum width; must be >= 2*WIDTH+clog2(LANES), elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  current operand beat is valid.
- clr_pipe_in  input  1  beat starts a new accumulation (sampled only with run).
- done_psum_in  input  1  beat is the last of an accumulation (sampled only with run).
- stall  input  1  freeze every pipeline register.
- sat_en  input  1  1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH (sampled at stage 3).
- Filter  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- IFMap  input  LANES*WIDTH  same packing as Filter.
- Psum  output  ACC_WIDTH  accumulator value.
- psum_valid  output  1  one-cycle strobe: Psum updated this cycle.
- done_psum  output  1  one-cycle strobe, coincident with psum_valid of the done beat.
- overflow  output  1  sticky accumulation overflow flag.

Behaviour:
- Reset (async, rst=1): every register cleared. Psum=0, psum_valid=0, done_psum=0, overflow=0. In-flight beats are discarded.
- Stage 1 (S1): per-lane unsigned products (2*WIDTH bits each) registered together with the run/clr/done tags.
- Stage 2 (S2): combinational adder tree over the S1 products; the SUM_W = 2*WIDTH+clog2(LANES) result is registered with its tags.
- Stage 3 (S3), when the S2 tag valid=1:
  - clr tag=1: acc_next = zero-extended sum.
  - clr tag=0: acc_next = Psum + sum, computed ACC_WIDTH+1 bits wide.
- Overflow when acc_next bit ACC_WIDTH = 1:
  - sat_en=1: Psum = all ones.
  - sat_en=0: Psum = low ACC_WIDTH bits.
  - overflow is set in both modes.
- overflow is cleared when a clr beat commits at S3, then re-evaluated for that beat; it is otherwise held.
- Latency: a beat presented with run at edge N updates Psum at edge N+3. psum_valid and done_psum are high during the following cycle.
- run=0 beats are bubbles: no Psum change, psum_valid=0. Tags propagate as invalid.
- stall=1: all stages, Psum, overflow and the strobes hold their current value. Inputs are ignored that cycle. Latency extends one cycle per stalled cycle; no beat is lost or duplicated.
- A strobe held under stall stays high for the whole stall; it is one pulse per beat in unstalled time.
- clr and done on the same beat: single-beat result, done_psum asserted with that value.
- Back-to-back accumulations: a clr beat immediately after a done beat is legal; no bubble is required.
- clr/done with run=0: ignored.

Decomposition:
- Shared package:
  - clog2 function.
  - PROD_W = 2*WIDTH, SUM_W = 2*WIDTH+clog2(LANES).
  - Tag bundle typedef {valid, clr, done}.
- One sub-module, product_tree: lane multipliers, S1 registers, S2 adder tree and S2 register, with stall honoured. mac_pipeline_multi adds tag pipeline and the S3 accumulator.
- Existing register, multiplier and adder cells are reused where widths fit.

Test Plan (WIDTH=8, LANES=4, ACC_WIDTH=20):
- Single-beat sum: Filter lanes all 2, IFMap lanes 3,4,5,6, run=clr=done=1 for one cycle.
  - Expect Psum=36, psum_valid=1 and done_psum=1 for exactly one cycle, 3 edges later; overflow=0.
- Four-beat accumulation: all lanes 255x255 (260100 per beat), clr on beat 1, done on beat 4.
  - Expect Psum steps 260100, 520200, 780300, 1040400; done_psum only with 1040400.
- Saturation, continuing the four-beat case with a fifth beat (total 1300500 > 1048575):
  - sat_en=1: expect Psum=1048575, overflow=1.
  - Rerun with sat_en=0: expect Psum=251924, overflow=1.
  - Next clr beat with sum 36: expect overflow=0, Psum=36.
- Stall and bubbles: 3 beats of sum 36 with a run=0 gap after beat 1 and stall=1 for 2 cycles after beat 2.
  - Expect final Psum=108 with all outputs frozen during the stall.
  - Expect done latency = 3 + 1 bubble + 2 stall edges; exactly 3 psum_valid pulses.
- Reset mid-operation: assert rst asynchronously while 2 beats are in flight.
  - Expect Psum, strobes and overflow at 0 immediately.
  - After release, no pulse from the discarded beats.
- Back-to-back: beat A (clr+done, sum 36) immediately followed by beat B (clr+done, sum 10).
  - Expect consecutive cycles Psum=36 with done_psum=1, then Psum=10 with done_psum=1.
